// File: rtl/bfp_pkg.sv
// Shared types and helpers for the float-to-BFP block quantizer.
// Field-width helpers, lane bundle, FSM states and rounding modes.
package bfp_pkg;

    function automatic int ew_of(int bw, int fpm);
        return bw - fpm - 1;
    endfunction

    function automatic int bias_of(int bw, int fpm);
        return (1 << (bw - fpm - 2)) - 1;
    endfunction

    localparam int LANE_MAG_W = 16;

    typedef struct packed {
        logic                  sign;
        logic [LANE_MAG_W-1:0] mag;
    } lane_t;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    localparam int RND_TRUNC   = 0;
    localparam int RND_HALF_UP = 1;

endpackage

// File: rtl/bfp_block_quantizer_align.sv
// One lane: float plus block exponent to sign-magnitude BFP mantissa.
// Purely combinational; flags all-ones exponents as special.
module bfp_lane_align
    import bfp_pkg::*;
#(
    parameter  int BIT  = 32,
    parameter  int FPM  = 23,
    parameter  int BFPM = 16,
    parameter  int RND  = 1,
    localparam int EW   = ew_of(BIT, FPM)
) (
    input  logic [BIT-1:0]  fp,
    input  logic [EW-1:0]   max_exp,
    output logic            sign,
    output logic [BFPM-1:0] mag,
    output logic            special
);

    localparam int SH = FPM + 1 - BFPM;
    localparam logic [EW:0] DLIM = (EW+1)'(FPM + 1);

    logic [EW-1:0] e;
    logic [EW-1:0] d;
    logic [31:0]   sh;
    logic [BFPM:0] t;
    logic [BFPM:0] sum;
    logic          rnd_add;

    always_comb begin
        e       = fp[BIT-2:FPM];
        d       = max_exp - e;
        sign    = fp[BIT-1];
        special = &e;
        sh      = 32'(d) + 32'(SH);
        // keep one guard bit below the output LSB for rounding
        t       = (BFPM+1)'({1'b1, fp[FPM-1:0], 1'b0} >> sh);
        rnd_add = (RND == RND_HALF_UP) && t[0];
        sum     = {1'b0, t[BFPM:1]} + {{BFPM{1'b0}}, rnd_add};
        mag     = sum[BFPM] ? '1 : sum[BFPM-1:0];
        if (e == '0 || special || {1'b0, d} >= DLIM) begin
            mag = '0;
        end
    end

endmodule

// File: rtl/bfp_block_quantizer.sv
// Collects a float vector, tracks its largest exponent, then replays it
// as shared-exponent sign-magnitude mantissas, P lanes per beat.
module bfp_block_quantizer
    import bfp_pkg::*;
#(
    parameter  int V    = 8,
    parameter  int P    = 2,
    parameter  int BIT  = 32,
    parameter  int FPM  = 23,
    parameter  int BFPM = 16,
    parameter  int RND  = 1,
    localparam int EW   = ew_of(BIT, FPM)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [P*BIT-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [P*(BFPM+1)-1:0] out_mant,
    output logic [EW-1:0]         out_exp,
    output logic                  out_last,
    output logic                  out_special
);

    localparam int NB = V / P;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int IW = (V > 1) ? $clog2(V) : 1;
    localparam int LW = BFPM + 1;

    state_t         state;
    state_t         state_n;
    logic [CW-1:0]  in_cnt;
    logic [CW-1:0]  out_cnt;
    logic [EW-1:0]  max_exp;
    logic [EW-1:0]  beat_max;
    logic [EW-1:0]  lane_e;
    logic           special;
    logic           beat_special;
    logic           in_fire;
    logic           out_fire;
    logic           in_last;
    logic           out_end;
    logic [BIT-1:0] buffer [V];
    logic [BIT-1:0] rd_word [P];
    logic           l_sign [P];
    logic [BFPM-1:0] l_mag [P];
    logic [P-1:0]   l_special;

    assign in_ready  = (state == COLLECT) && !reset;
    assign out_valid = (state == EMIT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign in_last   = (in_cnt == CW'(NB - 1));
    assign out_end   = (out_cnt == CW'(NB - 1));

    always_comb begin
        beat_max     = max_exp;
        beat_special = special;
        lane_e       = '0;
        for (int p = 0; p < P; p++) begin
            lane_e = in_data[p*BIT+FPM +: EW];
            if (lane_e > beat_max) begin
                beat_max = lane_e;
            end
            beat_special = beat_special | (&lane_e);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            COLLECT: if (in_fire && in_last) state_n = EMIT;
            EMIT:    if (out_fire && out_end) state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            max_exp <= '0;
            special <= 1'b0;
        end else begin
            if (in_fire) begin
                max_exp <= beat_max;
                special <= beat_special;
                in_cnt  <= in_last ? '0 : in_cnt + 1'b1;
            end
            if (out_fire) begin
                if (out_end) begin
                    out_cnt <= '0;
                    max_exp <= '0;
                    special <= 1'b0;
                end else begin
                    out_cnt <= out_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int p = 0; p < P; p++) begin
                buffer[IW'(in_cnt) * IW'(P) + IW'(p)] <= in_data[p*BIT +: BIT];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < P; p++) begin
            rd_word[p] = buffer[IW'(out_cnt) * IW'(P) + IW'(p)];
        end
    end

    for (genvar g = 0; g < P; g++) begin : g_lane
        bfp_lane_align #(
            .BIT  (BIT),
            .FPM  (FPM),
            .BFPM (BFPM),
            .RND  (RND)
        ) u_align (
            .fp      (rd_word[g]),
            .max_exp (max_exp),
            .sign    (l_sign[g]),
            .mag     (l_mag[g]),
            .special (l_special[g])
        );
    end

    // outputs depend only on state, buffer, max_exp and out_cnt
    always_comb begin
        out_mant = '0;
        if (out_valid) begin
            for (int p = 0; p < P; p++) begin
                out_mant[p*LW +: LW] = {l_sign[p], l_mag[p]};
            end
        end
    end

    assign out_exp     = out_valid ? max_exp : '0;
    assign out_last    = out_valid && out_end;
    assign out_special = out_valid && (special || (|l_special));

endmodule

// File: tb/tb_bfp_block_quantizer.sv
// Directed bench for bfp_block_quantizer with an arithmetic reference model.
// Two DUTs share inputs: default rounding and truncation.
module tb_bfp_block_quantizer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready_t;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_valid_t;
    logic        out_ready;
    logic [33:0] out_mant;
    logic [33:0] out_mant_t;
    logic [7:0]  out_exp;
    logic [7:0]  out_exp_t;
    logic        out_last;
    logic        out_last_t;
    logic        out_special;
    logic        out_special_t;

    int vectors = 0;
    int miscompares = 0;
    bit started = 0;

    typedef struct {
        logic [33:0] m1;
        logic [33:0] m0;
        logic [7:0]  e;
        logic        last;
        logic        sp;
    } beat_t;

    beat_t q[$];
    logic [31:0] blk [8];

    always #5 clk = ~clk;

    bfp_block_quantizer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp), .out_last(out_last),
        .out_special(out_special)
    );

    bfp_block_quantizer #(.RND(0)) dut_t (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_t),
        .in_data(in_data), .out_valid(out_valid_t), .out_ready(out_ready),
        .out_mant(out_mant_t), .out_exp(out_exp_t), .out_last(out_last_t),
        .out_special(out_special_t)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // mantissa = value / 2^(maxe - bias - 15), computed on the integer significand
    function automatic logic [16:0] model_lane(logic [31:0] w, int maxe, bit rnd);
        int     e;
        int     s;
        longint sig;
        longint qv;
        e   = int'(w[30:23]);
        sig = longint'({1'b1, w[22:0]});
        if (e == 0 || e == 255 || maxe - e >= 24) return {w[31], 16'h0};
        s = maxe - e + 8;
        if (rnd) qv = (sig + (64'sd1 <<< (s - 1))) >>> s;
        else     qv = sig >>> s;
        if (qv > 65535) qv = 65535;
        return {w[31], qv[15:0]};
    endfunction

    task automatic push_block();
        int   maxe;
        bit   sp;
        beat_t bt;
        maxe = 0;
        sp = 0;
        for (int i = 0; i < 8; i++) begin
            if (int'(blk[i][30:23]) > maxe) maxe = int'(blk[i][30:23]);
            if (blk[i][30:23] == 8'hFF) sp = 1;
        end
        for (int b = 0; b < 4; b++) begin
            bt.m1   = {model_lane(blk[2*b+1], maxe, 1), model_lane(blk[2*b], maxe, 1)};
            bt.m0   = {model_lane(blk[2*b+1], maxe, 0), model_lane(blk[2*b], maxe, 0)};
            bt.e    = 8'(maxe);
            bt.last = (b == 3);
            bt.sp   = sp;
            q.push_back(bt);
        end
    endtask

    task automatic feed(int nbeats);
        int n;
        for (int b = 0; b < nbeats; b++) begin
            n = 0;
            while (!in_ready && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
            in_data  = {blk[2*b+1], blk[2*b]};
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        if (nbeats == 4) check("latency", 64'(out_valid), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_remaining", 64'(q.size()), 64'd0);
        q.delete();
        #1;
    endtask

    task automatic set_default();
        blk = '{32'h3FC00000, 32'h40200000, 32'h40600000, 32'h40900000,
                32'h3FC00000, 32'h40200000, 32'h40600000, 32'h40900000};
    endtask

    always @(negedge clk) begin
        if (started && !reset) begin
            check("in_ready_vs_valid", 64'(in_ready), 64'(!out_valid));
            check("valid_pair", 64'(out_valid_t), 64'(out_valid));
            if (out_valid) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got mant %0h expected none", out_mant);
                end else begin
                    check("mant_rnd", 64'(out_mant), 64'(q[0].m1));
                    check("mant_trunc", 64'(out_mant_t), 64'(q[0].m0));
                    check("exp", 64'(out_exp), 64'(q[0].e));
                    check("last", 64'(out_last), 64'(q[0].last));
                    check("special", 64'(out_special), 64'(q[0].sp));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("post_rst_out", {out_mant, out_exp, out_last, out_special}, 64'd0);
        started = 1;

        check("model_neg45", 64'(model_lane(32'hC0900000, 129, 1)), 64'h19000);
        check("model_sat", 64'(model_lane(32'h3FFFFF80, 127, 1)), 64'h0FFFF);

        set_default();
        push_block();
        feed(4);
        check("dflt_exp", 64'(out_exp), 64'd129);
        check("dflt_beat0", 64'(out_mant), {30'd0, 17'h05000, 17'h03000});
        drain();

        set_default();
        blk[3] = 32'hC0900000;
        push_block();
        feed(4);
        drain();

        set_default();
        blk[0] = 32'h3F800000;
        blk[1] = 32'h4B800000;
        push_block();
        feed(4);
        check("big_exp", 64'(out_exp), 64'd151);
        check("big_beat0", 64'(out_mant), {30'd0, 17'h08000, 17'h00000});
        drain();

        blk = '{32'h3F800080, 32'h3FFFFF80, 32'h3F800000, 32'h3FC00000,
                32'hBF800080, 32'h3F000001, 32'h3FA00000, 32'h3F800100};
        push_block();
        feed(4);
        check("rnd_beat0", 64'(out_mant), {30'd0, 17'h0FFFF, 17'h08001});
        check("trunc_beat0", 64'(out_mant_t), {30'd0, 17'h0FFFF, 17'h08000});
        drain();

        set_default();
        push_block();
        feed(4);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stall_exp", 64'(out_exp), 64'd129);
        check("stall_beat1", 64'(out_mant), {30'd0, 17'h09000, 17'h07000});
        out_ready = 1'b1;
        drain();

        blk = '{32'h41000000, 32'h41000000, 32'h41000000, 32'h41000000,
                32'h41000000, 32'h41000000, 32'h41000000, 32'h41000000};
        feed(2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_default();
        push_block();
        feed(4);
        check("after_rst_exp", 64'(out_exp), 64'd129);
        drain();

        blk = '{32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000,
                32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        push_block();
        feed(4);
        check("zero_exp", 64'(out_exp), 64'd0);
        check("zero_special", 64'(out_special), 64'd0);
        check("zero_beat0", 64'(out_mant), {30'd0, 17'h10000, 17'h00000});
        drain();

        set_default();
        blk[0] = 32'h7F800000;
        blk[1] = 32'h3F800000;
        push_block();
        feed(4);
        check("inf_special", 64'(out_special), 64'd1);
        check("inf_exp", 64'(out_exp), 64'd255);
        check("inf_beat0", 64'(out_mant), 64'd0);
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
